// File: rtl/ipsl_hmic_h_ddrphy_update_exec_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ipsl_hmic_h_ddrphy_update_exec_if                                          |
// | Update request fields plus DFI phyupd req/ack handshake bundle.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface ipsl_hmic_h_ddrphy_update_exec_if;
  logic       update_start;
  logic [1:0] ddrphy_update_type;
  logic [1:0] ddrphy_update_comp_val_l;
  logic       ddrphy_update_comp_dir_l;
  logic [1:0] ddrphy_update_comp_val_h;
  logic       ddrphy_update_comp_dir_h;
  logic       ddrphy_update_done;
  logic       dfi_phyupd_req;
  logic       dfi_phyupd_ack;

  // Requester/controller side.
  modport master (
    output update_start, ddrphy_update_type,
           ddrphy_update_comp_val_l, ddrphy_update_comp_dir_l,
           ddrphy_update_comp_val_h, ddrphy_update_comp_dir_h,
           dfi_phyupd_ack,
    input  ddrphy_update_done, dfi_phyupd_req
  );

  // PHY update executor side.
  modport slave (
    input  update_start, ddrphy_update_type,
           ddrphy_update_comp_val_l, ddrphy_update_comp_dir_l,
           ddrphy_update_comp_val_h, ddrphy_update_comp_dir_h,
           dfi_phyupd_ack,
    output ddrphy_update_done, dfi_phyupd_req
  );
endinterface
`default_nettype wire

// File: rtl/ipsl_hmic_h_ddrphy_update_exec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ipsl_hmic_h_ddrphy_update_exec                                             |
// | PHY update responder: DFI phyupd handshake, DLL re-lock, DQS gate trim.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ipsl_hmic_h_ddrphy_update_exec #(
  parameter string DATA_WIDTH     = "16BIT",
  parameter int    DLL_UPD_PULSE  = 8,
  parameter int    DLL_SETTLE_CNT = 64,
  parameter int    ACK_TIMEOUT    = 1023
) (
  input  logic                                   rclk,
  input  logic                                   rst,
  ipsl_hmic_h_ddrphy_update_exec_if.slave        upd,
  output logic                                   dll_update_n_o,
  input  logic                                   dll_lock_i,
  input  logic                                   gate_load_i,
  input  logic [7:0]                             gate_init_l_i,
  input  logic [7:0]                             gate_init_h_i,
  output logic [7:0]                             dqs_gate_l_o,
  output logic [7:0]                             dqs_gate_h_o,
  output logic                                   gate_sat_err_o,
  output logic                                   ack_timeout_err_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_DLL_PULSE = 3'd2,
    ST_DLL_WAIT  = 3'd3,
    ST_GATE_ADJ  = 3'd4,
    ST_DONE      = 3'd5,
    ST_RELEASE   = 3'd6
  } state_e;

  localparam logic [15:0] c_ACK_LAST    = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] c_PULSE_LAST  = 16'(DLL_UPD_PULSE - 1);
  localparam logic [15:0] c_SETTLE_LAST = 16'(DLL_SETTLE_CNT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        is_gate_q, is_gate_d;
  logic [1:0]  val_l_q, val_l_d, val_h_q, val_h_d;
  logic        dir_l_q, dir_l_d, dir_h_q, dir_h_d;
  logic [7:0]  gate_l_q, gate_l_d, gate_h_q, gate_h_d;
  logic        sat_err_q, sat_err_d, to_err_q, to_err_d;
  logic        done_q, done_d, req_q, req_d, dll_n_q, dll_n_d;
  logic [8:0]  w_adj_l, w_adj_h;

  // Bit 8 flags a clamp; bits 7:0 carry the clamped gate value.
  function automatic logic [8:0] f_adjust(input logic [7:0] g, input logic [1:0] v,
                                          input logic up);
    logic [8:0] r;
    if (up) begin
      r = {1'b0, g} + {7'b0, v};
      f_adjust = r[8] ? 9'h1FF : {1'b0, r[7:0]};
    end else begin
      r = {1'b0, g} - {7'b0, v};
      f_adjust = r[8] ? 9'h100 : {1'b0, r[7:0]};
    end
  endfunction

  assign w_adj_l = f_adjust(gate_l_q, val_l_q, dir_l_q);

  generate
    if (DATA_WIDTH == "8BIT") begin : g_lane_h_fixed
      logic w_unused_h;
      assign w_unused_h = ^{val_h_q, dir_h_q};
      assign w_adj_h    = {1'b0, gate_h_q};
    end else begin : g_lane_h_adj
      assign w_adj_h = f_adjust(gate_h_q, val_h_q, dir_h_q);
    end
  endgenerate

  always_ff @(posedge rclk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_gate_d = is_gate_q;
    val_l_d   = val_l_q;
    dir_l_d   = dir_l_q;
    val_h_d   = val_h_q;
    dir_h_d   = dir_h_q;
    gate_l_d  = gate_l_q;
    gate_h_d  = gate_h_q;
    sat_err_d = sat_err_q;
    to_err_d  = to_err_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (gate_load_i) begin
          gate_l_d = gate_init_l_i;
          gate_h_d = gate_init_h_i;
        end
        if (upd.update_start) begin
          is_gate_d = upd.ddrphy_update_type[0];
          val_l_d   = upd.ddrphy_update_comp_val_l;
          dir_l_d   = upd.ddrphy_update_comp_dir_l;
          val_h_d   = upd.ddrphy_update_comp_val_h;
          dir_h_d   = upd.ddrphy_update_comp_dir_h;
          state_d   = upd.ddrphy_update_type[1] ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (upd.dfi_phyupd_ack) begin
          cnt_d   = '0;
          state_d = is_gate_q ? ST_GATE_ADJ : ST_DLL_PULSE;
        end else if (cnt_q == c_ACK_LAST) begin
          to_err_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DLL_PULSE: begin
        if (cnt_q == c_PULSE_LAST) begin
          cnt_d   = '0;
          state_d = ST_DLL_WAIT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DLL_WAIT: begin
        // Counter parks once the settle window has elapsed; lock may arrive much later.
        if (cnt_q >= c_SETTLE_LAST) begin
          if (dll_lock_i) state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_GATE_ADJ: begin
        gate_l_d  = w_adj_l[7:0];
        gate_h_d  = w_adj_h[7:0];
        sat_err_d = sat_err_q | w_adj_l[8] | w_adj_h[8];
        state_d   = ST_DONE;
      end
      ST_DONE:    state_d = ST_RELEASE;
      ST_RELEASE: if (!upd.update_start) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    done_d  = (state_d == ST_DONE);
    req_d   = (state_d == ST_REQ) || (state_d == ST_DLL_PULSE) ||
              (state_d == ST_DLL_WAIT) || (state_d == ST_GATE_ADJ);
    dll_n_d = (state_d != ST_DLL_PULSE);
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      cnt_q     <= '0;
      is_gate_q <= 1'b0;
      val_l_q   <= '0;
      dir_l_q   <= 1'b0;
      val_h_q   <= '0;
      dir_h_q   <= 1'b0;
      gate_l_q  <= '0;
      gate_h_q  <= '0;
      sat_err_q <= 1'b0;
      to_err_q  <= 1'b0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
      dll_n_q   <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      is_gate_q <= is_gate_d;
      val_l_q   <= val_l_d;
      dir_l_q   <= dir_l_d;
      val_h_q   <= val_h_d;
      dir_h_q   <= dir_h_d;
      gate_l_q  <= gate_l_d;
      gate_h_q  <= gate_h_d;
      sat_err_q <= sat_err_d;
      to_err_q  <= to_err_d;
      done_q    <= done_d;
      req_q     <= req_d;
      dll_n_q   <= dll_n_d;
    end
  end

  assign upd.ddrphy_update_done = done_q;
  assign upd.dfi_phyupd_req     = req_q;
  assign dll_update_n_o         = dll_n_q;
  assign dqs_gate_l_o           = gate_l_q;
  assign dqs_gate_h_o           = gate_h_q;
  assign gate_sat_err_o         = sat_err_q;
  assign ack_timeout_err_o      = to_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ipsl_hmic_h_ddrphy_update_exec.sv
`default_nettype none
// Bench: 16-bit and 8-bit instances share one stimulus stream and are compared every
// cycle against an expected-waveform timeline derived from each request's parameters.
module tb_ipsl_hmic_h_ddrphy_update_exec;
  localparam int PULSE  = 8;
  localparam int SETTLE = 64;
  localparam int TMO    = 16;
  localparam int MAXC   = 1024;

  logic rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic       rst, start, dl_in, dh_in, ack, lock, gload;
  logic [1:0] typ_in, vl_in, vh_in;
  logic [7:0] init_l, init_h;

  ipsl_hmic_h_ddrphy_update_exec_if if16 ();
  ipsl_hmic_h_ddrphy_update_exec_if if8 ();

  assign if16.update_start             = start;
  assign if16.ddrphy_update_type       = typ_in;
  assign if16.ddrphy_update_comp_val_l = vl_in;
  assign if16.ddrphy_update_comp_dir_l = dl_in;
  assign if16.ddrphy_update_comp_val_h = vh_in;
  assign if16.ddrphy_update_comp_dir_h = dh_in;
  assign if16.dfi_phyupd_ack           = ack;
  assign if8.update_start              = start;
  assign if8.ddrphy_update_type        = typ_in;
  assign if8.ddrphy_update_comp_val_l  = vl_in;
  assign if8.ddrphy_update_comp_dir_l  = dl_in;
  assign if8.ddrphy_update_comp_val_h  = vh_in;
  assign if8.ddrphy_update_comp_dir_h  = dh_in;
  assign if8.dfi_phyupd_ack            = ack;

  logic       dlln16, dlln8, sat16, sat8, to16, to8;
  logic [7:0] gl16, gh16, gl8, gh8;

  ipsl_hmic_h_ddrphy_update_exec #(
    .DATA_WIDTH("16BIT"), .DLL_UPD_PULSE(PULSE), .DLL_SETTLE_CNT(SETTLE), .ACK_TIMEOUT(TMO)
  ) dut16 (
    .rclk(rclk), .rst(rst), .upd(if16),
    .dll_update_n_o(dlln16), .dll_lock_i(lock), .gate_load_i(gload),
    .gate_init_l_i(init_l), .gate_init_h_i(init_h),
    .dqs_gate_l_o(gl16), .dqs_gate_h_o(gh16),
    .gate_sat_err_o(sat16), .ack_timeout_err_o(to16)
  );

  ipsl_hmic_h_ddrphy_update_exec #(
    .DATA_WIDTH("8BIT"), .DLL_UPD_PULSE(PULSE), .DLL_SETTLE_CNT(SETTLE), .ACK_TIMEOUT(TMO)
  ) dut8 (
    .rclk(rclk), .rst(rst), .upd(if8),
    .dll_update_n_o(dlln8), .dll_lock_i(lock), .gate_load_i(gload),
    .gate_init_l_i(init_l), .gate_init_h_i(init_h),
    .dqs_gate_l_o(gl8), .dqs_gate_h_o(gh8),
    .gate_sat_err_o(sat8), .ack_timeout_err_o(to8)
  );

  int cyc = 0;
  always @(posedge rclk) cyc <= cyc + 1;

  // Expected output timeline, indexed by cycle number.
  logic       exp_req [MAXC];
  logic       exp_done[MAXC];
  logic       exp_dlln[MAXC];
  logic [7:0] exp_gl  [MAXC];
  logic [7:0] exp_gh16[MAXC];
  logic [7:0] exp_gh8 [MAXC];
  logic       exp_sat16[MAXC];
  logic       exp_sat8 [MAXC];
  logic       exp_to   [MAXC];

  int m_gl, m_gh16, m_gh8;
  bit m_sat16, m_sat8, m_to;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int last_done = -1;
  int dlln_low = 0;
  bit running  = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic mark_req(input int a, input int b);
    for (int i = a; i <= b && i < MAXC; i++) exp_req[i] = 1'b1;
  endtask

  task automatic mark_pulse(input int a, input int b);
    for (int i = a; i <= b && i < MAXC; i++) exp_dlln[i] = 1'b0;
  endtask

  task automatic hold_state(input int c);
    for (int i = c; i < MAXC; i++) begin
      exp_gl[i]    = 8'(m_gl);
      exp_gh16[i]  = 8'(m_gh16);
      exp_gh8[i]   = 8'(m_gh8);
      exp_sat16[i] = m_sat16;
      exp_sat8[i]  = m_sat8;
      exp_to[i]    = m_to;
    end
  endtask

  function automatic int clamp(input int r);
    return (r > 255) ? 255 : ((r < 0) ? 0 : r);
  endfunction

  task automatic adjust(input int vl, input bit dl, input int vh, input bit dh);
    int r;
    r = dl ? m_gl + vl : m_gl - vl;
    if (r > 255 || r < 0) begin m_sat16 = 1'b1; m_sat8 = 1'b1; end
    m_gl = clamp(r);
    r = dh ? m_gh16 + vh : m_gh16 - vh;
    if (r > 255 || r < 0) m_sat16 = 1'b1;
    m_gh16 = clamp(r);
  endtask

  task automatic load_gates(input logic [7:0] l, input logic [7:0] h);
    gload = 1'b1; init_l = l; init_h = h;
    m_gl = int'(l); m_gh16 = int'(h); m_gh8 = int'(h);
    hold_state(cyc + 1);
    tick();
    gload = 1'b0;
  endtask

  // ack_dly < 0: never acknowledge. lock_dly: cycles after the last pulse cycle.
  task automatic do_update(input logic [1:0] typ, input logic [1:0] vl, input logic dl,
                           input logic [1:0] vh, input logic dh, input int ack_dly,
                           input int lock_dly, input bit load, input logic [7:0] il,
                           input logic [7:0] ih, input int hold_extra, output int t0);
    int ta, lk, done_c, drop_c;
    t0 = cyc;
    start = 1'b1; typ_in = typ; vl_in = vl; dl_in = dl; vh_in = vh; dh_in = dh;
    gload = load; init_l = il; init_h = ih;
    ta = t0 + 1 + ack_dly;
    lk = MAXC;
    if (load) begin
      m_gl = int'(il); m_gh16 = int'(ih); m_gh8 = int'(ih);
      hold_state(t0 + 1);
    end
    if (typ[1]) begin
      done_c = t0 + 1;
    end else if (ack_dly < 0) begin
      mark_req(t0 + 1, t0 + TMO);
      done_c = t0 + TMO + 1;
      m_to = 1'b1;
      hold_state(done_c);
    end else if (typ[0]) begin
      mark_req(t0 + 1, ta + 1);
      done_c = ta + 2;
      adjust(int'(vl), dl, int'(vh), dh);
      hold_state(done_c);
    end else begin
      mark_pulse(ta + 1, ta + PULSE);
      lk = ta + PULSE + lock_dly;
      done_c = ((lk > ta + PULSE + SETTLE) ? lk : ta + PULSE + SETTLE) + 1;
      mark_req(t0 + 1, done_c - 1);
    end
    exp_done[done_c] = 1'b1;
    drop_c = done_c + 1 + hold_extra;
    tick();
    typ_in = ~typ; vl_in = ~vl; dl_in = ~dl; vh_in = ~vh; dh_in = ~dh;
    while (cyc < drop_c) begin
      ack   = (ack_dly >= 0) && (cyc == ta);
      lock  = (cyc >= lk);
      gload = (cyc == t0 + 1);
      init_l = 8'hAA; init_h = 8'h55;
      tick();
    end
    start = 1'b0; ack = 1'b0; lock = 1'b0; gload = 1'b0;
    tick();
  endtask

  always @(negedge rclk) begin
    if (running && cyc >= 1 && cyc < MAXC) begin
      if (if16.ddrphy_update_done === 1'b1) begin done_cnt++; last_done = cyc; end
      if (dlln16 === 1'b0) dlln_low++;
      check("req16",  32'(if16.dfi_phyupd_req),     32'(exp_req[cyc]));
      check("done16", 32'(if16.ddrphy_update_done), 32'(exp_done[cyc]));
      check("dlln16", 32'(dlln16),                  32'(exp_dlln[cyc]));
      check("gl16",   32'(gl16),                    32'(exp_gl[cyc]));
      check("gh16",   32'(gh16),                    32'(exp_gh16[cyc]));
      check("sat16",  32'(sat16),                   32'(exp_sat16[cyc]));
      check("to16",   32'(to16),                    32'(exp_to[cyc]));
      check("req8",   32'(if8.dfi_phyupd_req),      32'(exp_req[cyc]));
      check("done8",  32'(if8.ddrphy_update_done),  32'(exp_done[cyc]));
      check("dlln8",  32'(dlln8),                   32'(exp_dlln[cyc]));
      check("gl8",    32'(gl8),                     32'(exp_gl[cyc]));
      check("gh8",    32'(gh8),                     32'(exp_gh8[cyc]));
      check("sat8",   32'(sat8),                    32'(exp_sat8[cyc]));
      check("to8",    32'(to8),                     32'(exp_to[cyc]));
    end
  end

  initial begin
    int t0, ta;
    for (int i = 0; i < MAXC; i++) begin
      exp_req[i] = 1'b0; exp_done[i] = 1'b0; exp_dlln[i] = 1'b1;
      exp_gl[i] = 8'h00; exp_gh16[i] = 8'h00; exp_gh8[i] = 8'h00;
      exp_sat16[i] = 1'b0; exp_sat8[i] = 1'b0; exp_to[i] = 1'b0;
    end
    m_gl = 0; m_gh16 = 0; m_gh8 = 0; m_sat16 = 1'b0; m_sat8 = 1'b0; m_to = 1'b0;
    rst = 1'b1; start = 1'b0; typ_in = 2'b00; vl_in = 2'b00; vh_in = 2'b00;
    dl_in = 1'b0; dh_in = 1'b0; ack = 1'b0; lock = 1'b0; gload = 1'b0;
    init_l = 8'h00; init_h = 8'h00;
    tick(); tick(); tick();
    rst = 1'b0;
    check("reset dll_update_n", 32'(dlln16), 32'd1);
    check("reset req", 32'(if16.dfi_phyupd_req), 32'd0);

    // Gate trim: +2 low, -1 high, ack three cycles after req.
    load_gates(8'h40, 8'h20);
    do_update(2'b01, 2'd2, 1'b1, 2'd1, 1'b0, 3, 0, 1'b0, 8'h00, 8'h00, 0, t0);
    check("trim done offset", 32'(last_done - t0), 32'd6);
    check("trim gate_l", 32'(gl16), 32'h42);
    check("trim gate_h", 32'(gh16), 32'h1F);
    check("8bit gate_h kept", 32'(gh8), 32'h20);
    check("8bit gate_l", 32'(gl8), 32'h42);

    // DLL re-lock, lock arriving 100 cycles after the pulse.
    dlln_low = 0;
    do_update(2'b00, 2'd0, 1'b0, 2'd0, 1'b0, 3, 100, 1'b0, 8'h00, 8'h00, 0, t0);
    check("dll pulse length", 32'(dlln_low), 32'd8);
    check("dll late lock done offset", 32'(last_done - t0), 32'd113);

    // DLL re-lock with lock already high: settle window sets the latency.
    do_update(2'b00, 2'd0, 1'b0, 2'd0, 1'b0, 3, 0, 1'b0, 8'h00, 8'h00, 0, t0);
    check("dll settle done offset", 32'(last_done - t0), 32'd77);

    // Saturation, with gate load in the same cycle as the start.
    do_update(2'b01, 2'd3, 1'b1, 2'd3, 1'b0, 2, 0, 1'b1, 8'hFE, 8'h01, 0, t0);
    check("sat gate_l", 32'(gl16), 32'hFF);
    check("sat gate_h", 32'(gh16), 32'h00);
    check("sat err", 32'(sat16), 32'd1);
    check("8bit sat gate_h", 32'(gh8), 32'h01);

    // Clean update keeps the sticky flag; ack in the first REQ cycle.
    do_update(2'b01, 2'd1, 1'b0, 2'd1, 1'b1, 0, 0, 1'b0, 8'h00, 8'h00, 0, t0);
    check("clean gate_l", 32'(gl16), 32'hFE);
    check("clean gate_h", 32'(gh16), 32'h01);
    check("sticky sat err", 32'(sat16), 32'd1);

    // Ack timeout, request level held long after done.
    done_cnt = 0;
    do_update(2'b01, 2'd1, 1'b1, 2'd1, 1'b1, -1, 0, 1'b0, 8'h00, 8'h00, 20, t0);
    check("timeout done count", 32'(done_cnt), 32'd1);
    check("timeout done offset", 32'(last_done - t0), 32'd17);
    check("timeout err", 32'(to16), 32'd1);
    check("timeout gate_l", 32'(gl16), 32'hFE);

    // No-op types.
    do_update(2'b10, 2'd3, 1'b1, 2'd3, 1'b1, -1, 0, 1'b0, 8'h00, 8'h00, 0, t0);
    check("type10 done offset", 32'(last_done - t0), 32'd1);
    do_update(2'b11, 2'd3, 1'b1, 2'd3, 1'b1, -1, 0, 1'b0, 8'h00, 8'h00, 0, t0);
    check("type11 done offset", 32'(last_done - t0), 32'd1);

    // Reset in the middle of the DLL pulse.
    t0 = cyc;
    start = 1'b1; typ_in = 2'b00;
    ta = t0 + 4;
    mark_req(t0 + 1, ta + 3);
    mark_pulse(ta + 1, ta + 3);
    tick();
    while (cyc < ta + 3) begin
      ack = (cyc == ta);
      tick();
    end
    ack = 1'b0;
    check("pulse active before rst", 32'(dlln16), 32'd0);
    rst = 1'b1;
    m_gl = 0; m_gh16 = 0; m_gh8 = 0; m_sat16 = 1'b0; m_sat8 = 1'b0; m_to = 1'b0;
    hold_state(ta + 4);
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst dll_update_n", 32'(dlln16), 32'd1);
    check("rst req", 32'(if16.dfi_phyupd_req), 32'd0);
    check("rst done", 32'(if16.ddrphy_update_done), 32'd0);
    check("rst gate_l", 32'(gl16), 32'd0);
    tick();

    // Recovery: reload and trim, val_l = 0 must not flag.
    load_gates(8'h10, 8'h10);
    do_update(2'b01, 2'd0, 1'b1, 2'd2, 1'b1, 1, 0, 1'b0, 8'h00, 8'h00, 0, t0);
    check("reload gate_l", 32'(gl16), 32'h10);
    check("reload gate_h", 32'(gh16), 32'h12);
    check("reload sat err", 32'(sat16), 32'd0);
    check("reload 8bit gate_h", 32'(gh8), 32'h10);

    check("cycle budget", 32'(cyc < MAXC), 32'd1);
    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
